// File: rtl/operand_loader_derizq.sv
// Serial LSB-first operand loader with registered result capture.
// Optional shadow-load overlap: define DERIZQ_LOADER_OVERLAP_EN.
module operand_loader_derizq #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         a_bit,
    input  logic         b_bit,
    output logic [N-1:0] A_out,
    output logic [N-1:0] B_out,
    input  logic         z_in,
    output logic         z_out,
    output logic         z_valid,
    input  logic         z_ready
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        LOAD,
        EVAL,
        HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          acc;
    logic          zhs;

    function automatic logic [N-1:0] setbit(
        input logic [N-1:0]  v,
        input logic [CW-1:0] p,
        input logic          b
    );
        logic [N-1:0] r;
        r = v;
        for (int i = 0; i < N; i++) begin
            if (p == CW'(i)) r[i] = b;
        end
        return r;
    endfunction

    assign acc = in_valid && in_ready;
    assign zhs = z_valid && z_ready;

`ifdef DERIZQ_LOADER_OVERLAP_EN
    logic [N-1:0]  sa, sb, sa_nx, sb_nx;
    logic [CW-1:0] scnt, scnt_nx;
    logic          sacc;

    assign in_ready = (state == LOAD) ||
                      ((state == HOLD) && (scnt < CW'(N)));
    assign sacc     = acc && (state == HOLD);

    // Shadow write lands before any same-cycle transfer to the live words.
    always_comb begin
        sa_nx   = sa;
        sb_nx   = sb;
        scnt_nx = scnt;
        if (sacc) begin
            sa_nx   = setbit(sa, scnt, a_bit);
            sb_nx   = setbit(sb, scnt, b_bit);
            scnt_nx = scnt + CW'(1);
        end
    end
`else
    assign in_ready = (state == LOAD);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            cnt     <= '0;
            A_out   <= '0;
            B_out   <= '0;
            z_out   <= 1'b0;
            z_valid <= 1'b0;
`ifdef DERIZQ_LOADER_OVERLAP_EN
            sa      <= '0;
            sb      <= '0;
            scnt    <= '0;
`endif
        end else begin
            unique case (state)
                LOAD: begin
                    if (acc) begin
                        A_out <= setbit(A_out, cnt, a_bit);
                        B_out <= setbit(B_out, cnt, b_bit);
                        cnt   <= cnt + CW'(1);
                        if (cnt == CW'(N - 1)) state <= EVAL;
                    end
                end
                EVAL: begin
                    z_out   <= z_in;
                    z_valid <= 1'b1;
                    state   <= HOLD;
                end
                HOLD: begin
`ifdef DERIZQ_LOADER_OVERLAP_EN
                    if (zhs) begin
                        z_valid <= 1'b0;
                        A_out   <= sa_nx;
                        B_out   <= sb_nx;
                        cnt     <= scnt_nx;
                        sa      <= '0;
                        sb      <= '0;
                        scnt    <= '0;
                        state   <= (scnt_nx == CW'(N)) ? EVAL : LOAD;
                    end else begin
                        sa   <= sa_nx;
                        sb   <= sb_nx;
                        scnt <= scnt_nx;
                    end
`else
                    if (zhs) begin
                        z_valid <= 1'b0;
                        A_out   <= '0;
                        B_out   <= '0;
                        cnt     <= '0;
                        state   <= LOAD;
                    end
`endif
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_loader_derizq.sv
// Directed bench for operand_loader_derizq (N=3 and N=2 instances).
module tb_operand_loader_derizq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv, ir, ab, bb, zi, zo, zv, zr;
    logic [2:0] ao, bo;
    logic       iv2, ir2, ab2, bb2, zi2, zo2, zv2, zr2;
    logic [1:0] ao2, bo2;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    operand_loader_derizq #(.N(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv), .in_ready(ir),
        .a_bit(ab), .b_bit(bb),
        .A_out(ao), .B_out(bo),
        .z_in(zi), .z_out(zo),
        .z_valid(zv), .z_ready(zr)
    );

    operand_loader_derizq #(.N(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv2), .in_ready(ir2),
        .a_bit(ab2), .b_bit(bb2),
        .A_out(ao2), .B_out(bo2),
        .z_in(zi2), .z_out(zo2),
        .z_valid(zv2), .z_ready(zr2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        iv = 0; ab = 0; bb = 0; zi = 0; zr = 0;
        iv2 = 0; ab2 = 0; bb2 = 0; zi2 = 0; zr2 = 0;
        step();
        step();
        chk("rst_a", ao, 3'b000);
        chk("rst_zv", zv, 1'b0);
        chk("rst_zo", zo, 1'b0);
        chk("rst2_a", ao2, 2'b00);
        rst_n = 1'b1;
        step();
        chk("rel_ir", ir, 1'b1);

        // two bits then asynchronous reset mid-load
        iv = 1; ab = 1; bb = 1;
        step();
        step();
        iv = 0;
        chk("part_a", ao, 3'b011);
        chk("part_b", bo, 3'b011);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a", ao, 3'b000);
        chk("arst_b", bo, 3'b000);
        chk("arst_zv", zv, 1'b0);
        chk("arst_ir", ir, 1'b1);
        step();
        rst_n = 1'b1;

        // pairs (0,0),(1,0),(0,0): a full load is needed again
        iv = 1; ab = 0; bb = 0;
        step();
        ab = 1;
        step();
        chk("ld2_ir", ir, 1'b1);
        ab = 0;
        step();
        iv = 0;
        chk("ev_ir", ir, 1'b0);
        chk("ev_a", ao, 3'b010);
        chk("ev_b", bo, 3'b000);
        zi = 1;
        step();
        chk("cap_zv", zv, 1'b1);
        chk("cap_zo", zo, 1'b1);

        // stall in HOLD with noise on z_in and in_valid
        ab = 1; bb = 1;
        for (int i = 0; i < 5; i++) begin
            zi = ~zi;
            iv = ~iv;
            step();
            chk("hold_zo", zo, 1'b1);
            chk("hold_zv", zv, 1'b1);
            chk("hold_ir", ir, 1'b0);
            chk("hold_a", ao, 3'b010);
        end
        iv = 0;
        zr = 1;
        step();
        zr = 0;
        chk("hs_zv", zv, 1'b0);
        chk("hs_a", ao, 3'b000);
        chk("hs_b", bo, 3'b000);
        chk("hs_ir", ir, 1'b1);

        // bubbles: A=101 B=011
        iv = 0; ab = 0; bb = 0;
        step();
        iv = 1; ab = 1; bb = 1;
        step();
        iv = 0; ab = 0; bb = 0;
        step();
        iv = 1; ab = 0; bb = 1;
        step();
        iv = 0; ab = 1; bb = 1;
        step();
        chk("bub_ir", ir, 1'b1);
        chk("bub_a2", ao, 3'b001);
        chk("bub_b2", bo, 3'b011);
        iv = 1; ab = 1; bb = 0;
        step();
        iv = 0;
        chk("bub_ev_ir", ir, 1'b0);
        chk("bub_a", ao, 3'b101);
        chk("bub_b", bo, 3'b011);
        zi = 0;
        step();
        chk("bub_zv", zv, 1'b1);
        chk("bub_zo", zo, 1'b0);
        zr = 1;
        step();
        chk("bub_hs", zv, 1'b0);

        // back-to-back: 111/101 then 001/110, z_ready held high
        iv = 1; ab = 1; bb = 1;
        step();
        bb = 0;
        step();
        bb = 1;
        step();
        chk("bb1_a", ao, 3'b111);
        chk("bb1_b", bo, 3'b101);
        zi = 1;
        ab = 1; bb = 0;
        step();
        chk("bb1_zv", zv, 1'b1);
        chk("bb1_zo", zo, 1'b1);
        chk("bb1_hold_a", ao, 3'b111);
        step();
        chk("bb1_hs", zv, 1'b0);
        chk("bb1_clr", ao, 3'b000);
        chk("bb1_ir", ir, 1'b1);
        step();
        chk("bb2_a0", ao, 3'b001);
        chk("bb2_b0", bo, 3'b000);
        ab = 0; bb = 1;
        step();
        chk("bb2_b1", bo, 3'b010);
        step();
        iv = 0;
        chk("bb2_a", ao, 3'b001);
        chk("bb2_b", bo, 3'b110);
        chk("bb2_ir", ir, 1'b0);
        zi = 0;
        step();
        chk("bb2_zv", zv, 1'b1);
        chk("bb2_zo", zo, 1'b0);
        step();
        chk("bb2_hs", zv, 1'b0);
        zr = 0;

        // N=2 instance: (1,0),(1,1)
        iv2 = 1; ab2 = 1; bb2 = 0;
        step();
        bb2 = 1;
        step();
        iv2 = 0;
        chk("n2_a", ao2, 2'b11);
        chk("n2_b", bo2, 2'b10);
        chk("n2_ir", ir2, 1'b0);
        zi2 = 1;
        step();
        zi2 = 0;
        chk("n2_zv", zv2, 1'b1);
        chk("n2_zo", zo2, 1'b1);
        zr2 = 1;
        step();
        chk("n2_hs", zv2, 1'b0);
        chk("n2_clr", ao2, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/operand_loader_derizq.md
# operand_loader_derizq

Serial operand loader and result capture stage upstream of the right-to-left iterative comparison network. It accepts operand bit pairs (a_bit, b_bit) one per handshake, LSB first, and assembles them into N-bit words A_out and B_out. It holds the words stable while the combinational network evaluates them, then registers the network's single-bit result and presents it downstream with a valid/ready handshake.

## Interface
- N, 3, operand width; N ≥ 2; must match the network's N.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low; single clock domain.
- in_valid  input  1  upstream bit pair valid.
- in_ready  output  1  loader can accept a bit pair.
- a_bit  input  1  next bit of A, LSB first.
- b_bit  input  1  next bit of B, LSB first.
- A_out  output  N  operand A to the network's A input.
- B_out  output  N  operand B to the network's B input.
- z_in  input  1  network result (Zout), combinational from A_out and B_out.
- z_out  output  1  registered result.
- z_valid  output  1  z_out valid.
- z_ready  input  1  downstream accepts z_out.

## Operation
- State machine has three states: LOAD, EVAL and HOLD. The bit counter cnt is $clog2(N+1) bits wide and runs from 0 to N.
- A bit pair is accepted when in_valid && in_ready is high at a rising edge. On accept, a_bit and b_bit are written to bit position cnt, and cnt increments.
- LOAD:
  - in_ready=1.
  - Bits not yet loaded read as 0.
  - The accept that sets cnt to N moves the state to EVAL.
- EVAL: lasts one cycle.
  - in_ready=0.
  - A_out and B_out are stable, and z_in settles.
  - At the closing edge, z_out<=z_in and z_valid<=1, and the state moves to HOLD.
- HOLD:
  - z_valid=1 and z_out is held.
  - When z_valid && z_ready is high at an edge: z_valid<=0, A_out<=0, B_out<=0, cnt<=0, and the state moves to LOAD.
- in_ready is decoded combinationally from state and cnt only. It never depends on in_valid.
- in_valid in EVAL or HOLD is ignored. No bit is consumed.
- Reset, asynchronous and usable mid-operation:
  - state=LOAD, cnt=0.
  - A_out=0, B_out=0.
  - z_out=0, z_valid=0.
  - in_ready=1 once rst_n is released.
  - Any partial operand or pending result is discarded.

## Timing
- Last bit accepted at edge k → EVAL in cycle k..k+1 → z_valid=1 and z_out valid after edge k+1.
- Minimum operation period is N+2 cycles: N accepts, 1 EVAL cycle, 1 HOLD cycle with z_ready=1.
- z_ready held high in HOLD completes the handshake in that same cycle. A new bit can be accepted starting the cycle after.
- z_in is sampled only at the end of EVAL. Changes on z_in at any other time have no effect.

## Configuration
- Macro: DERIZQ_LOADER_OVERLAP_EN.
- Without the macro, behaviour is exactly as described above. in_ready=0 throughout EVAL and HOLD.
- With the macro:
  - The loader has shadow registers SA/SB and a shadow counter scnt.
  - In HOLD, in_ready=(scnt<N). Accepted bits go to SA and SB at position scnt, and A_out and B_out stay frozen.
  - On the z handshake: A_out<=SA, B_out<=SB, cnt<=scnt, then SA, SB and scnt are cleared.
  - The next state is EVAL if scnt==N, otherwise LOAD.
  - A bit accepted in the same cycle as the z handshake is written into the shadow before the transfer.
  - Reset clears the shadow state as well.
  - This removes the reload gap: back-to-back operations can run at N+1 cycles each.

## Test plan
- Reset with rst_n=0 in the middle of a LOAD after 2 bits, N=3 → A_out=0, B_out=0, z_valid=0, cnt=0. After release, in_ready=1 and a full 3-bit load is required before EVAL.
- Accept pairs (0,0),(1,0),(0,0) on consecutive edges with in_valid=1 → A_out=3'b010 and B_out=3'b000 during EVAL. Bench drives z_in=1 in EVAL → z_out=1 and z_valid=1 one edge after the third accept.
- Keep z_ready=0 for 5 cycles in HOLD, toggling z_in and in_valid → z_out stays 1, z_valid stays 1, in_ready=0, and no bits are consumed (non-overlap build). Then z_ready=1 → z_valid=0 and A_out/B_out=0 next cycle.
- in_valid bubbles: pairs presented with in_valid low every other cycle → A_out and B_out assemble correctly, and EVAL begins only after the Nth accept.
- Back-to-back operations with A=3'b111/B=3'b101 then A=3'b001/B=3'b110, with z_ready=1 constantly → two results in 2×(N+2)=10 cycles in the non-overlap build. In the build with DERIZQ_LOADER_OVERLAP_EN, A_out=3'b001 appears in the cycle after the first result's handshake.
- N=2 instance: pairs (1,0),(1,1) → A_out=2'b11, B_out=2'b10, z captured at end of EVAL.
